// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - bundle of requester, response and multiplier signals for mult_arbiter
//
// Purpose: groups every handshake/bus signal of the arbiter so the block and
// its environment connect through one port.
// Modports:
//   slave  - the arbiter: takes requests and multiplier results, drives
//            ready pulses, responses and the multiplier controls.
//   master - the environment: requesters, response sink and multiplier.
// Signals:
//   req0_valid/req1_valid, req0_op1/op2, req1_op1/op2  requester side
//   req0_ready/req1_ready                               one-cycle accept pulses
//   resp_valid, resp_id, resp_err, resp_product         result return
//   mult_begin, mult_op1, mult_op2                      multiplier start/operands
//   product, mult_end                                   multiplier result/done

interface mult_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [31:0] req0_op1;
  logic [31:0] req0_op2;
  logic [31:0] req1_op1;
  logic [31:0] req1_op2;
  logic        req0_ready;
  logic        req1_ready;

  logic        resp_valid;
  logic        resp_id;
  logic        resp_err;
  logic [63:0] resp_product;

  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;

  modport slave (
    input  req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_err, resp_product,
    output mult_begin, mult_op1, mult_op2,
    input  product, mult_end
  );

  modport master (
    output req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_err, resp_product,
    input  mult_begin, mult_op1, mult_op2,
    output product, mult_end
  );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one iterative multiplier between two requesters
//
// Purpose: accepts operand pairs from requester 0 or 1, runs them one at a
// time on an external multiplier, and returns the product tagged with the
// requester id. A BUSY cycle counter aborts operations whose mult_end never
// arrives (resp_err=1, resp_product=0).
// Parameters:
//   TIMEOUT - BUSY cycles waited for mult_end before abort (2..255).
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   bus    - mult_arbiter_if.slave (requests, responses, multiplier)

module mult_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           resetn,
  mult_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] BUSY_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] busy_cnt;
  logic       last_grant;   // 1 = requester 1 was granted last, so 0 wins a tie
  logic       cur_id;
  logic       grant0;
  logic       grant1;
  logic       idle_open;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    grant1 = bus.req1_valid && !grant0;
  end

  // Ready has to pulse in the accepting IDLE cycle itself, so it is decoded
  // from the registered state; resetn gates it so reset forces it low at once.
  assign idle_open      = resetn && (state == IDLE);
  assign bus.req0_ready = idle_open && grant0;
  assign bus.req1_ready = idle_open && grant1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      busy_cnt         <= 8'd0;
      last_grant       <= 1'b1;
      cur_id           <= 1'b0;
      bus.mult_begin   <= 1'b0;
      bus.mult_op1     <= 32'd0;
      bus.mult_op2     <= 32'd0;
      bus.resp_valid   <= 1'b0;
      bus.resp_id      <= 1'b0;
      bus.resp_err     <= 1'b0;
      bus.resp_product <= 64'd0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            bus.mult_op1   <= grant1 ? bus.req1_op1 : bus.req0_op1;
            bus.mult_op2   <= grant1 ? bus.req1_op2 : bus.req0_op2;
            cur_id         <= grant1;
            last_grant     <= grant1;
            busy_cnt       <= 8'd0;
            bus.mult_begin <= 1'b1;
            state          <= BUSY;
          end
        end
        BUSY: begin
          // mult_end is checked first so a result arriving on the timeout
          // cycle still completes normally.
          if (bus.mult_end) begin
            bus.resp_product <= bus.product;
            bus.resp_err     <= 1'b0;
            bus.resp_id      <= cur_id;
            bus.resp_valid   <= 1'b1;
            bus.mult_begin   <= 1'b0;
            state            <= GAP;
          end else if (busy_cnt == BUSY_LAST) begin
            bus.resp_product <= 64'd0;
            bus.resp_err     <= 1'b1;
            bus.resp_id      <= cur_id;
            bus.resp_valid   <= 1'b1;
            bus.mult_begin   <= 1'b0;
            state            <= GAP;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        GAP: begin
          // One cycle with mult_begin low lets the multiplier clear.
          state <= IDLE;
        end
        default: begin
          state          <= IDLE;
          bus.mult_begin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, max BUSY cycles waited for mult_end before abort (legal range 2..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester N has an operand pair pending; held until its ready pulse.
REQ-005 req0_op1, req0_op2, req1_op1, req1_op2  input  32 each  operands of requester N; stable while reqN_valid=1.
REQ-006 req0_ready / req1_ready  output  1 each  one-cycle pulse: request N accepted this cycle.
REQ-007 resp_valid  output  1  one-cycle pulse: result available on resp_* this cycle.
REQ-008 resp_id  output  1  requester the result belongs to (0/1).
REQ-009 resp_err  output  1  1 = operation aborted by timeout; resp_product is then 0.
REQ-010 resp_product  output  64  product returned; held until next resp_valid.
REQ-011 mult_begin  output  1  drives multiplier start; held high for the whole operation.
REQ-012 mult_op1, mult_op2  output  32 each  registered operands to the multiplier; stable while mult_begin=1.
REQ-013 product  input  64  multiplier result; valid when mult_end=1.
REQ-014 mult_end  input  1  multiplier done indication.

Function
REQ-015 The block SHALL serialise both requesters onto one shared iterative multiplier using states IDLE, BUSY, GAP.
REQ-016 In IDLE with any reqN_valid=1, the block SHALL pulse the granted reqN_ready, latch that requester's operands into mult_op1/mult_op2, record its id, and enter BUSY next cycle.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; the last-grant flag updates only on acceptance.
REQ-018 At most one reqN_ready SHALL be high in any cycle, and never outside IDLE.
REQ-019 mult_begin SHALL be 1 exactly while in BUSY (registered; first high in the cycle after acceptance).
REQ-020 In BUSY, mult_end=1 SHALL cause capture of product into resp_product, resp_err=0, transition to GAP, and resp_valid pulse in the cycle GAP is entered.
REQ-021 A 8-bit BUSY cycle counter SHALL clear on entry to BUSY; if it reaches TIMEOUT-1 with mult_end=0, the block SHALL enter GAP with resp_valid=1, resp_err=1, resp_product=0.
REQ-022 mult_end sampled on the same cycle the timeout fires SHALL win (normal completion, resp_err=0).
REQ-023 GAP SHALL last exactly one cycle with mult_begin=0 so the multiplier clears, then return to IDLE; no acceptance in GAP.
REQ-024 mult_end while not in BUSY SHALL be ignored.
REQ-025 Best-case accept-to-accept interval SHALL be multiplier latency + 3 cycles (BUSY entry, GAP, IDLE).
REQ-026 reqN_valid dropping while not granted SHALL not be treated as an error; the request is simply not served.

Reset
REQ-027 resetn=0 SHALL immediately force state IDLE, mult_begin=0, mult_op1=mult_op2=0, req0_ready=req1_ready=0, resp_valid=0, resp_id=0, resp_err=0, resp_product=0, counter=0, last-grant=1 (requester 0 wins first tie).
REQ-028 Reset asserted mid-BUSY SHALL abort the operation with no resp_valid issued for it.

Verification
REQ-029 Single request: req0 op1=0x00001111, op2=0x00001111 -> req0_ready pulse, mult_begin high until mult_end, resp_valid with resp_id=0, resp_err=0, resp_product=0x0000000001234321.
REQ-030 Contention: req0 and req1 valid together from reset, req1 ops 0x00001111 x 0x00002222 -> req0 served first, req1 next; second resp has resp_id=1, resp_product=0x0000000002468642.
REQ-031 Fairness: both held valid for 4 operations -> grants alternate 0,1,0,1; no back-to-back grant to the same requester.
REQ-032 Timeout: multiplier model never asserts mult_end, TIMEOUT=16 -> resp_valid after 16 BUSY cycles with resp_err=1, resp_product=0, mult_begin low one cycle, next request served normally.
REQ-033 Reset mid-operation: resetn low 3 cycles into BUSY -> all outputs at reset values asynchronously, no resp_valid; request 0x00000002 x 0xFFFFFFFF after reset completes normally with product from the multiplier model.
REQ-034 Gap check: every operation shows mult_begin=0 for at least one cycle between consecutive mult_begin high periods.
